// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage register file.
// WB_REGFILE_BYPASS_EN (optional macro, used in wb_regfile.sv) enables
// write-through bypass from the WB write port to the ID read ports.
package wb_regfile_pkg;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int RADDR_W = 5;

    // Bit positions inside the 2-bit WB control field
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // An all-zero instruction word marks a pipeline bubble
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    function automatic logic is_bubble(input logic [31:0] instr);
        return (instr == BUBBLE_INSTR);
    endfunction

endpackage

// File: rtl/wb_regfile_retire_counter.sv
// Retired-instruction counter: 64-bit free-wrapping count of non-bubble
// instructions plus a copy of the most recent one. Kept separate so the
// CSR file can reuse it (e.g. for mcycle with a never-bubble input).
import wb_regfile_pkg::*;

module retire_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_instr,
    output logic [63:0] o_count,
    output logic [31:0] o_last
);

    logic [63:0] r_count;
    logic [31:0] r_last;
    logic        w_enable;

    assign w_enable = !is_bubble(i_instr);

    // Count every retiring instruction and remember it; wraps silently at 2^64
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 64'd0;
            r_last  <= BUBBLE_INSTR;
        end else if (w_enable) begin
            r_count <= r_count + 64'd1;
            r_last  <= i_instr;
        end
    end

    assign o_count = r_count;
    assign o_last  = r_last;

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: consumer end of the MEM->WB pipeline register. Selects the
// write-back value, writes the architectural register file, serves the two
// ID read ports and counts retired instructions.
// Optional macro: WB_REGFILE_BYPASS_EN -- when defined, a read of the index
// being written this cycle returns the write-back value (no WB->ID stall);
// when undefined, reads always return storage (pre-write value).
import wb_regfile_pkg::*;

module wb_regfile #(
    parameter int XLEN_P    = XLEN,
    parameter int NREG_P    = NREG,
    parameter int RADDR_W_P = RADDR_W   // must equal log2(NREG_P)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           wb_ctrl,
    input  logic [XLEN_P-1:0]    wb_aluout,
    input  logic [XLEN_P-1:0]    wb_memdata,
    input  logic [RADDR_W_P-1:0] wb_rd,
    input  logic [31:0]          wb_instruction,
    input  logic [RADDR_W_P-1:0] rs1_addr,
    input  logic [RADDR_W_P-1:0] rs2_addr,
    output logic [XLEN_P-1:0]    rs1_data,
    output logic [XLEN_P-1:0]    rs2_data,
    output logic [XLEN_P-1:0]    wb_wdata,
    output logic [63:0]          instret,
    output logic [31:0]          last_retired
);

    logic [XLEN_P-1:0] w_wdata;
    logic              w_wen;
    logic [XLEN_P-1:0] w_regs [NREG_P];
    logic [XLEN_P-1:0] w_rs1_store;
    logic [XLEN_P-1:0] w_rs2_store;

    // Write-back value: load data or ALU result, purely combinational
    assign w_wdata  = wb_ctrl[WB_MEMTOREG] ? wb_memdata : wb_aluout;
    assign wb_wdata = w_wdata;

    // x0 never takes a write
    assign w_wen = wb_ctrl[WB_REGWRITE] && (wb_rd != '0);

    // One flop bank per register; x0 is a constant zero, not storage.
    // Asynchronous reset means this cannot map onto block RAM by design.
    generate
        for (genvar gi = 0; gi < NREG_P; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic [XLEN_P-1:0] r_q;

                // Capture the write-back value when this index is targeted
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (w_wen && (wb_rd == RADDR_W_P'(gi))) begin
                        r_q <= w_wdata;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    // Storage read; index 0 is forced to zero explicitly
    assign w_rs1_store = (rs1_addr == '0) ? '0 : w_regs[rs1_addr];
    assign w_rs2_store = (rs2_addr == '0) ? '0 : w_regs[rs2_addr];

    // Read ports, optionally forwarding the value being written this cycle
    always_comb begin
        rs1_data = w_rs1_store;
        rs2_data = w_rs2_store;
`ifdef WB_REGFILE_BYPASS_EN
        if (w_wen && (rs1_addr == wb_rd)) begin
            rs1_data = w_wdata;
        end
        if (w_wen && (rs2_addr == wb_rd)) begin
            rs2_data = w_wdata;
        end
`endif
    end

    retire_counter u_retire (
        .clk     (clk),
        .rst     (rst),
        .i_instr (wb_instruction),
        .o_count (instret),
        .o_last  (last_retired)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset, ALU/load write-back, x0 guard,
// same-cycle RAW (both build variants), bubbles, 64-bit wrap, async reset.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_ctrl;
    logic [31:0] wb_aluout;
    logic [31:0] wb_memdata;
    logic [4:0]  wb_rd;
    logic [31:0] wb_instruction;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_wdata;
    logic [63:0] instret;
    logic [31:0] last_retired;

    int n_tests;
    int n_fail;

    wb_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .wb_ctrl        (wb_ctrl),
        .wb_aluout      (wb_aluout),
        .wb_memdata     (wb_memdata),
        .wb_rd          (wb_rd),
        .wb_instruction (wb_instruction),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .wb_wdata       (wb_wdata),
        .instret        (instret),
        .last_retired   (last_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Drive one WB beat (called just after a negedge)
    task automatic beat(input logic [1:0] ctrl, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] instr);
        wb_ctrl        = ctrl;
        wb_rd          = rd;
        wb_aluout      = alu;
        wb_memdata     = mem;
        wb_instruction = instr;
    endtask

    task automatic bubble();
        beat(2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst      = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        bubble();

        // Reset then read
        repeat (3) @(negedge clk);
        check("reset_rs1_during", {32'h0, rs1_data}, 64'h0);
        rst = 1'b0;
        step();
        check("reset_rs1", {32'h0, rs1_data}, 64'h0);
        check("reset_rs2", {32'h0, rs2_data}, 64'h0);
        check("reset_instret", instret, 64'h0);
        check("reset_last", {32'h0, last_retired}, 64'h0);

        // ALU write to x3
        beat(2'b10, 5'd3, 32'hDEADBEEF, 32'h0BADF00D, 32'h00A00193);
        #1 check("alu_wdata", {32'h0, wb_wdata}, 64'hDEADBEEF);
        step();
        bubble();
        rs1_addr = 5'd3;
        #1;
        check("alu_rs1", {32'h0, rs1_data}, 64'hDEADBEEF);
        check("alu_instret", instret, 64'd1);
        check("alu_last", {32'h0, last_retired}, 64'h00A00193);

        // Load select with x0 destination: dropped
        @(negedge clk);
        beat(2'b11, 5'd0, 32'hAAAAAAAA, 32'h12345678, 32'h00002003);
        #1 check("load_wdata", {32'h0, wb_wdata}, 64'h12345678);
        step();
        bubble();
        rs1_addr = 5'd0;
        #1 check("x0_read", {32'h0, rs1_data}, 64'h0);
        check("x0_instret", instret, 64'd2);

        // Load into x7: memdata, not aluout
        @(negedge clk);
        beat(2'b11, 5'd7, 32'hAAAAAAAA, 32'h12345678, 32'h00002383);
        step();
        bubble();
        rs2_addr = 5'd7;
        #1 check("load_x7", {32'h0, rs2_data}, 64'h12345678);
        check("load_instret", instret, 64'd3);

        // Same-cycle RAW on x4 (x4 = 1 first)
        @(negedge clk);
        beat(2'b10, 5'd4, 32'd1, 32'h0, 32'h00100213);
        step();
        beat(2'b10, 5'd4, 32'd9, 32'h0, 32'h00900213);
        rs1_addr = 5'd4;
        rs2_addr = 5'd4;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("raw_rs1_same", {32'h0, rs1_data}, 64'd9);
        check("raw_rs2_same", {32'h0, rs2_data}, 64'd9);
`else
        check("raw_rs1_same", {32'h0, rs1_data}, 64'd1);
        check("raw_rs2_same", {32'h0, rs2_data}, 64'd1);
`endif
        step();
        bubble();
        #1;
        check("raw_rs1_next", {32'h0, rs1_data}, 64'd9);
        check("raw_rs2_next", {32'h0, rs2_data}, 64'd9);
        check("raw_instret", instret, 64'd5);

        // Three bubbles that still write x10
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            beat(2'b10, 5'd10, 32'h100 + 32'(i), 32'h0, 32'h0);
        end
        step();
        bubble();
        rs1_addr = 5'd10;
        #1;
        check("bubble_write", {32'h0, rs1_data}, 64'h102);
        check("bubble_instret", instret, 64'd5);
        check("bubble_last", {32'h0, last_retired}, 64'h00900213);

        // 64-bit wrap
        @(negedge clk);
        force dut.u_retire.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_retire.r_count;
        #1 check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(2'b00, 5'd0, 32'h0, 32'h0, 32'h00000013);
        step();
        bubble();
        #1;
        check("wrap_instret", instret, 64'h0);
        check("wrap_last", {32'h0, last_retired}, 64'h00000013);

        // Async reset mid-write: x8 = 55 first, then a write of 77 in flight
        @(negedge clk);
        beat(2'b10, 5'd8, 32'd55, 32'h0, 32'h00800413);
        step();
        beat(2'b10, 5'd8, 32'd77, 32'h0, 32'h04D00413);
        rs1_addr = 5'd8;
        #1;
`ifndef WB_REGFILE_BYPASS_EN
        check("pre_rst_x8", {32'h0, rs1_data}, 64'd55);
`else
        check("pre_rst_x8", {32'h0, rs1_data}, 64'd77);
`endif
        #1 rst = 1'b1;
        #1;
        check("arst_x8", {32'h0, rs1_data}, 64'h0);
        check("arst_instret", instret, 64'h0);
        check("arst_last", {32'h0, last_retired}, 64'h0);
        @(posedge clk);
        #1;
        check("arst_hold_x8", {32'h0, rs1_data}, 64'h0);
        check("arst_hold_instret", instret, 64'h0);
        @(negedge clk);
        bubble();
        rst = 1'b0;
        step();
        check("post_rst_x8", {32'h0, rs1_data}, 64'h0);
        rs1_addr = 5'd3;
        #1 check("post_rst_x3", {32'h0, rs1_data}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
